// File: rtl/arb_rr_if.sv
// Request/grant bundle between N requesters and the arb_rr arbiter.
interface arb_rr_if #(
  parameter int N = 4
);
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    req;
  logic [N-1:0]    grant;
  logic [IDXW-1:0] grant_idx;
  logic            grant_valid;

  modport master (output req, input grant, grant_idx, grant_valid);
  modport slave  (input req, output grant, grant_idx, grant_valid);
endinterface

// File: rtl/arb_rr.sv
// N-requester arbiter: registered one-hot grant, round-robin or fixed priority,
// with a burst limit that forces the holder to yield while others are waiting.
module arb_rr #(
  parameter int N        = 4,
  parameter int MODE     = 0,
  parameter int MAX_HOLD = 1
) (
  input logic     clk,
  input logic     reset,
  arb_rr_if.slave bus
);
  localparam int         IDXW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

  logic [N-1:0]    grant_q, grant_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic            vld_q, vld_d;
  logic [7:0]      hold_q, hold_d;

  logic            holder_req, others, keep, win;
  logic [N-1:0]    mreq, scan;
  logic [2*N-1:0]  dbl;
  logic [IDXW-1:0] win_idx;

  assign holder_req = vld_q && ((bus.req & grant_q) != '0);
  assign others     = (bus.req & ~grant_q) != '0;
  assign keep       = holder_req && ((hold_q < HOLD_LIM) || !others);

  // Whenever the holder is not kept its bit is either already clear or it is
  // being forced out, so masking the current grant is always correct here.
  assign mreq = bus.req & ~grant_q;
  assign dbl  = {mreq, mreq} >> ptr_q;
  assign scan = (MODE == 0) ? dbl[N-1:0] : mreq;

  // Scan downwards so the lowest offset from the start point wins.
  always_comb begin
    win     = 1'b0;
    win_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (scan[i]) begin
        win     = 1'b1;
        win_idx = (MODE == 0) ? IDXW'((int'(ptr_q) + i) % N) : IDXW'(i);
      end
    end
  end

  always_comb begin
    grant_d = grant_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    if (keep) begin
      if (hold_q < HOLD_LIM) hold_d = hold_q + 8'd1;
    end else if (win) begin
      grant_d          = '0;
      grant_d[win_idx] = 1'b1;
      idx_d            = win_idx;
      vld_d            = 1'b1;
      hold_d           = '0;
      ptr_d            = (win_idx == IDXW'(N - 1)) ? '0 : win_idx + IDXW'(1);
    end else begin
      grant_d = '0;
      idx_d   = '0;
      vld_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      grant_q <= grant_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = vld_q;
endmodule

// File: tb/tb_arb_rr.sv
// Three arbiter configurations driven side by side; a queue-based scoreboard
// compares each cycle's grant against a streak/priority-list reference model.
module tb_arb_rr;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  arb_rr_if #(.N(4)) bus0 ();
  arb_rr_if #(.N(4)) bus1 ();
  arb_rr_if #(.N(4)) bus2 ();

  arb_rr #(.N(4), .MODE(0), .MAX_HOLD(1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  arb_rr #(.N(4), .MODE(0), .MAX_HOLD(3)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  arb_rr #(.N(4), .MODE(1), .MAX_HOLD(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  logic [2:0][3:0] rq, gr;
  logic [2:0][1:0] gi;
  logic [2:0]      gv;

  assign bus0.req = rq[0];
  assign bus1.req = rq[1];
  assign bus2.req = rq[2];
  assign gr[0] = bus0.grant; assign gi[0] = bus0.grant_idx; assign gv[0] = bus0.grant_valid;
  assign gr[1] = bus1.grant; assign gi[1] = bus1.grant_idx; assign gv[1] = bus1.grant_valid;
  assign gr[2] = bus2.grant; assign gi[2] = bus2.grant_idx; assign gv[2] = bus2.grant_valid;

  typedef struct packed {
    logic [2:0][3:0] g;
    logic [2:0][1:0] ix;
    logic [2:0]      v;
  } exp_t;
  exp_t expq[$];

  int m_mode[3] = '{0, 0, 1};
  int m_hold[3] = '{1, 3, 2};
  int m_own[3];
  int m_streak[3];
  int m_ptr[3];
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [6:0] act, input logic [6:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: grant/idx/valid got %b/%b/%b want %b/%b/%b",
               nm, act[6:3], act[2:1], act[0], want[6:3], want[2:1], want[0]);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_own[d] = -1; m_streak[d] = 0; m_ptr[d] = 0;
    end
  endtask

  // Streak counts cycles held; priority list is built from the start pointer.
  task automatic model(input int d, input logic [3:0] r,
                       output logic [3:0] g, output logic [1:0] ix, output logic v);
    int own, excl, pick, c;
    bit others;
    own = m_own[d]; excl = -1; pick = -1; others = 0;
    for (int i = 0; i < 4; i++) if (r[i] && i != own) others = 1;
    if (own >= 0 && r[own] && (m_streak[d] < m_hold[d] || !others)) begin
      pick = own;
      m_streak[d]++;
    end else begin
      if (own >= 0 && r[own]) excl = own;
      for (int o = 0; o < 4; o++) begin
        c = (m_mode[d] == 0) ? (m_ptr[d] + o) % 4 : o;
        if (pick < 0 && r[c] && c != excl) pick = c;
      end
      if (pick >= 0) begin
        m_streak[d] = 1;
        m_ptr[d]    = (pick + 1) % 4;
      end
    end
    m_own[d] = pick;
    g  = (pick >= 0) ? 4'(1 << pick) : 4'b0000;
    ix = (pick >= 0) ? 2'(pick) : 2'd0;
    v  = (pick >= 0);
  endtask

  task automatic push_model();
    exp_t e;
    logic [3:0] g;
    logic [1:0] ix;
    logic v;
    e = '0;
    for (int d = 0; d < 3; d++) begin
      model(d, rq[d], g, ix, v);
      e.g[d] = g; e.ix[d] = ix; e.v[d] = v;
    end
    expq.push_back(e);
  endtask

  task automatic step(input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] r2);
    @(negedge clk);
    rq[0] = r0; rq[1] = r1; rq[2] = r2;
    push_model();
    @(posedge clk);
    #2;
  endtask

  // Called just after a step; asserts reset between edges and checks the clear.
  task automatic mid_reset(input string nm);
    #1;
    reset = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) check(nm, {gr[d], gi[d], gv[d]}, 7'b0000_00_0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Monitor: one-hot every cycle, plus a scoreboard pop per issued stimulus.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
        n_chk++;
        if (!$onehot0(gr[d])) begin
          n_fail++;
          $display("FAIL onehot dut%0d: grant=%b, at most one bit allowed", d, gr[d]);
        end
      end
      if (expq.size() > 0) begin
        e = expq.pop_front();
        for (int d = 0; d < 3; d++)
          check($sformatf("scoreboard dut%0d", d), {gr[d], gi[d], gv[d]},
                {e.g[d], e.ix[d], e.v[d]});
      end
    end
  end

  logic [3:0] c0 [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
  int         i0 [7] = '{0, 1, 2, 3, 0, 1, 2};
  logic [3:0] c1 [7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
  int         i1 [7] = '{0, 0, 0, 1, 1, 1, 0};
  logic [3:0] c2 [7] = '{4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0010, 4'b0010, 4'b0100};
  int         i2 [7] = '{1, 1, 2, 2, 1, 1, 2};
  logic [3:0] sr [5] = '{4'b1001, 4'b1000, 4'b1001, 4'b1001, 4'b1001};
  logic [3:0] sg [5] = '{4'b0001, 4'b1000, 4'b1000, 4'b1000, 4'b0001};
  int         si [5] = '{0, 3, 3, 3, 0};

  initial begin
    logic [2:0][3:0] nr;
    nr    = '0;
    rq    = '0;
    reset = 1'b1;
    model_reset();
    #3;
    for (int d = 0; d < 3; d++) check("reset state", {gr[d], gi[d], gv[d]}, 7'b0000_00_0);
    @(posedge clk);
    #2;
    reset = 1'b0;

    for (int k = 0; k < 3; k++) begin
      step(4'b0000, 4'b0000, 4'b0000);
      for (int d = 0; d < 3; d++) check("idle no req", {gr[d], gi[d], gv[d]}, 7'b0000_00_0);
    end

    // Fresh reset so the first decision starts from pointer 0.
    step(4'b0000, 4'b0000, 4'b0000);
    mid_reset("reset while idle");
    for (int k = 0; k < 7; k++) begin
      step(4'b1111, 4'b0011, 4'b0110);
      check("rr hold1 req1111", {gr[0], gi[0], gv[0]}, {c0[k], 2'(i0[k]), 1'b1});
      check("rr hold3 req0011", {gr[1], gi[1], gv[1]}, {c1[k], 2'(i1[k]), 1'b1});
      check("fixed hold2 req0110", {gr[2], gi[2], gv[2]}, {c2[k], 2'(i2[k]), 1'b1});
    end

    for (int k = 0; k < 10; k++) begin
      step(4'b0100, 4'b0100, 4'b0100);
      for (int d = 0; d < 3; d++) check("sole requester", {gr[d], gi[d], gv[d]}, 7'b0100_10_1);
    end

    mid_reset("reset mid hold");
    step(4'b1111, 4'b1111, 4'b1111);
    for (int d = 0; d < 3; d++) check("first grant after reset", {gr[d], gi[d], gv[d]}, 7'b0001_00_1);

    for (int k = 0; k < 5; k++) begin
      step(sr[k], sr[k], sr[k]);
      check("holder drop restarts hold", {gr[1], gi[1], gv[1]}, {sg[k], 2'(si[k]), 1'b1});
    end

    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 3; d++)
        if ($urandom_range(0, 2) == 0) nr[d] = 4'($urandom);
      step(nr[0], nr[1], nr[2]);
      if (c == 200) mid_reset("reset random phase");
    end

    step(4'b0000, 4'b0000, 4'b0000);
    n_chk++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, 0 expected", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
